// File: rtl/display_line_fetcher_pkg.sv
// display_line_fetcher_pkg: shared display line buffer geometry and fetch FSM states.
package display_line_fetcher_pkg;
   localparam int DISPLAY_WORDS_PER_LINE = 32;
   localparam int DISPLAY_BUF_ADDR_WIDTH = 6;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fetch_state_t;
endpackage

// File: rtl/display_line_fetcher.sv
// display_line_fetcher: refills the idle half of a ping-pong display line buffer
// from framebuffer memory at each scanout line start.
module display_line_fetcher
   import display_line_fetcher_pkg::*;
#(
   parameter int ADDR_WIDTH = 24,
   parameter int LINE_WIDTH = 10,
   parameter int LINE_COUNT = 768
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [ADDR_WIDTH-1:0]             fb_base,
   input  logic                              line_start,
   input  logic [LINE_WIDTH-1:0]             line_num,
   output logic                              scan_half,
   output logic [DISPLAY_BUF_ADDR_WIDTH-1:0] buf_write_addr,
   output logic [63:0]                       buf_write_data,
   output logic                              buf_write_enable,
   output logic                              mem_read_req,
   output logic [ADDR_WIDTH-1:0]             mem_read_addr,
   input  logic                              mem_read_ready,
   input  logic [63:0]                       mem_read_data,
   input  logic                              mem_read_data_valid,
   output logic                              busy,
   output logic                              underrun
);
   localparam int CW = $clog2(DISPLAY_WORDS_PER_LINE);
   localparam logic [CW-1:0] LAST = CW'(DISPLAY_WORDS_PER_LINE - 1);
   fetch_state_t state_q, state_d;
   logic scan_half_q, scan_half_d, fill_half_q, fill_half_d, underrun_q, underrun_d;
   logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
   logic [CW-1:0] issue_cnt_q, issue_cnt_d, ret_cnt_q, ret_cnt_d;
   logic [LINE_WIDTH-1:0] target;
   logic accept, ret;

   assign target = (line_num == LINE_WIDTH'(LINE_COUNT - 1)) ? '0 : line_num + 1'b1;
   assign busy = state_q != IDLE;
   assign mem_read_req = state_q == ISSUE;
   assign mem_read_addr = line_addr_q + ADDR_WIDTH'(issue_cnt_q);
   assign accept = mem_read_req & mem_read_ready;
   // Returns outside a fetch are stray and must not touch the buffer.
   assign ret = busy & mem_read_data_valid;
   assign buf_write_enable = ret;
   assign buf_write_addr = {fill_half_q, ret_cnt_q};
   assign buf_write_data = mem_read_data;
   assign scan_half = scan_half_q;
   assign underrun = underrun_q;

   always_comb begin
      state_d = state_q;
      scan_half_d = scan_half_q;
      fill_half_d = fill_half_q;
      line_addr_d = line_addr_q;
      issue_cnt_d = issue_cnt_q + CW'(accept);
      ret_cnt_d = ret_cnt_q + CW'(ret);
      underrun_d = line_start & busy;
      case (state_q)
         IDLE: if (line_start) begin
            state_d = ISSUE;
            scan_half_d = ~scan_half_q;
            fill_half_d = scan_half_q;
            line_addr_d = fb_base + (ADDR_WIDTH'(target) << CW);
            issue_cnt_d = '0;
            ret_cnt_d = '0;
         end
         // The final return can coincide with the final accept, so ISSUE may finish directly.
         ISSUE: state_d = (ret && ret_cnt_q == LAST) ? IDLE :
                          (accept && issue_cnt_q == LAST) ? DRAIN : ISSUE;
         DRAIN: state_d = (ret && ret_cnt_q == LAST) ? IDLE : DRAIN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         scan_half_q <= 1'b0;
         fill_half_q <= 1'b0;
         underrun_q <= 1'b0;
         line_addr_q <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         scan_half_q <= scan_half_d;
         fill_half_q <= fill_half_d;
         underrun_q <= underrun_d;
         line_addr_q <= line_addr_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q <= ret_cnt_d;
      end
   end
endmodule

// File: tb/tb_display_line_fetcher.sv
// tb_display_line_fetcher: table of line fetches against a 2-cycle-latency memory model,
// with a write scoreboard and corner-case modes (underrun, reset mid-fetch).
module tb_display_line_fetcher;
   logic clk = 0, reset = 1, line_start = 0, mem_read_ready = 0, mem_read_data_valid = 0;
   logic [23:0] fb_base = '0;
   logic [9:0] line_num = '0;
   logic [63:0] mem_read_data = '0;
   logic scan_half, buf_write_enable, mem_read_req, busy, underrun;
   logic [5:0] buf_write_addr;
   logic [63:0] buf_write_data;
   logic [23:0] mem_read_addr;

   typedef struct {logic [9:0] ln; logic [23:0] fb; int stall; logic [23:0] base; logic scan; int mode;} vec_t;
   typedef struct {int due; logic [63:0] d;} ret_t;
   typedef struct {logic [5:0] a; logic [63:0] d;} wr_t;
   ret_t rq[$];
   wr_t sb[$];
   vec_t tbl[8];
   int checks = 0, errors = 0, cyc = 0;

   display_line_fetcher dut (
      .clk(clk), .reset(reset), .fb_base(fb_base), .line_start(line_start), .line_num(line_num),
      .scan_half(scan_half), .buf_write_addr(buf_write_addr), .buf_write_data(buf_write_data),
      .buf_write_enable(buf_write_enable), .mem_read_req(mem_read_req), .mem_read_addr(mem_read_addr),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .mem_read_data_valid(mem_read_data_valid), .busy(busy), .underrun(underrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] mdata(input logic [23:0] a);
      return {8'hC3, a, 8'h3C, ~a};
   endfunction

   task automatic reset_checks();
      chk("rst_scan_half", scan_half, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req", mem_read_req, 0);
      chk("rst_we", buf_write_enable, 0);
      chk("rst_underrun", underrun, 0);
   endtask

   // mode: 0 plain, 1 line_start mid-ISSUE, 2 line_start on last write, 3 reset after 10 accepts
   task automatic fetch(input vec_t v);
      int acc = 0, wr = 0, n = 0;
      bit ur_next = 0, ls_done = 0, prev_stall = 0;
      logic [23:0] exp_addr = v.base, prev_addr = '0;
      wr_t w;
      fb_base = v.fb;
      line_num = v.ln;
      line_start = 1;
      mem_read_ready = 0;
      mem_read_data_valid = 0;
      @(posedge clk);
      @(negedge clk);
      line_start = 0;
      chk("flip_scan_half", scan_half, v.scan);
      chk("start_busy", busy, 1);
      chk("start_req", mem_read_req, 1);
      while (busy && n < 600) begin
         n++;
         mem_read_ready = ($urandom_range(99) >= v.stall);
         mem_read_data_valid = rq.size() > 0 && rq[0].due <= cyc;
         mem_read_data = mem_read_data_valid ? rq[0].d : 64'h0;
         #1;
         if (prev_stall) begin
            chk("stall_req_held", mem_read_req, 1);
            chk("stall_addr_held", mem_read_addr, prev_addr);
         end
         prev_stall = mem_read_req && !mem_read_ready;
         prev_addr = mem_read_addr;
         if (mem_read_req && mem_read_ready) begin
            chk("req_addr", mem_read_addr, exp_addr);
            rq.push_back('{cyc + 2, mdata(exp_addr)});
            sb.push_back('{{~v.scan, acc[4:0]}, mdata(exp_addr)});
            exp_addr++;
            acc++;
         end
         if (mem_read_data_valid) void'(rq.pop_front());
         chk("we_follows_valid", buf_write_enable, mem_read_data_valid);
         if (buf_write_enable) begin
            if (sb.size() == 0) chk("write_unexpected", 1, 0);
            else begin
               w = sb.pop_front();
               chk("write_addr", buf_write_addr, w.a);
               chk("write_data", buf_write_data, w.d);
            end
            wr++;
         end
         if (v.mode == 1 && acc == 5 && !ls_done) begin
            line_start = 1;
            ur_next = 1;
            ls_done = 1;
         end
         if (v.mode == 2 && wr == 32) begin
            line_start = 1;
            ur_next = 1;
         end
         if (v.mode == 3 && acc == 10) begin
            reset = 1;
            mem_read_ready = 0;
            mem_read_data_valid = 0;
            #1;
            reset_checks();
            rq.delete();
            sb.delete();
            @(posedge clk);
            @(negedge clk);
            reset = 0;
            return;
         end
         @(posedge clk);
         @(negedge clk);
         line_start = 0;
         chk("underrun", underrun, ur_next);
         ur_next = 0;
      end
      chk("fetch_done", busy, 0);
      chk("accept_count", acc, 32);
      chk("write_count", wr, 32);
      chk("scoreboard_empty", sb.size(), 0);
      chk("scan_half_kept", scan_half, v.scan);
      mem_read_ready = 0;
      mem_read_data_valid = 0;
      @(posedge clk);
      @(negedge clk);
      chk("idle_underrun", underrun, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      tbl[0] = '{10'd0,   24'h001000, 0,  24'h001020, 1'b1, 0};
      tbl[1] = '{10'd1,   24'h001000, 0,  24'h001040, 1'b0, 0};
      tbl[2] = '{10'd767, 24'h000000, 0,  24'h000000, 1'b1, 0};
      tbl[3] = '{10'd100, 24'hFFFFF0, 50, 24'h000C90, 1'b0, 0};
      tbl[4] = '{10'd5,   24'h123456, 30, 24'h123516, 1'b1, 1};
      tbl[5] = '{10'd9,   24'h000000, 0,  24'h000140, 1'b0, 2};
      tbl[6] = '{10'd20,  24'h002000, 20, 24'h0022A0, 1'b1, 3};
      tbl[7] = '{10'd20,  24'h002000, 0,  24'h0022A0, 1'b1, 0};
      #1;
      reset_checks();
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) fetch(tbl[i]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/display_line_fetcher.md
Name: display_line_fetcher

Overview:
Controller that keeps the 64-entry x 64-bit display line buffer fed from framebuffer memory. The buffer is split into two 32-word halves (ping-pong). On each scanout line start, the fetcher flips the half presented to scanout, then fetches the next line into the other half. It sits between the memory read port and the display buffer write port; scanout reads the buffer using scan_half as the top address bit.

Parameters:
ADDR_WIDTH, 24, framebuffer word (64-bit) address width
LINE_WIDTH, 10, width of line_num
LINE_COUNT, 768, visible lines per frame; next-line index wraps to 0 after LINE_COUNT-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
fb_base  input  ADDR_WIDTH  framebuffer base word address; sampled at line_start
line_start  input  1  one-cycle pulse: scanout begins line line_num
line_num  input  LINE_WIDTH  line scanout is starting; valid with line_start
scan_half  output  1  buffer half scanout reads (read_addr = {scan_half, word[4:0]})
buf_write_addr  output  6  display buffer write address
buf_write_data  output  64  display buffer write data
buf_write_enable  output  1  display buffer write strobe
mem_read_req  output  1  read request valid
mem_read_addr  output  ADDR_WIDTH  read word address
mem_read_ready  input  1  memory accepts request when req & ready
mem_read_data  input  64  read return data, in request order
mem_read_data_valid  input  1  return data valid
busy  output  1  fetch in progress (state != IDLE)
underrun  output  1  one-cycle pulse: line_start arrived while busy

Behaviour:
- Reset (async): state IDLE; scan_half=0; issue_cnt=0; ret_cnt=0; mem_read_req=0; underrun=0; busy=0; buf_write_enable=0.
- States: IDLE, ISSUE, DRAIN.
- IDLE + line_start: next cycle scan_half <= ~scan_half; fill_half <= old scan_half; target = (line_num == LINE_COUNT-1) ? 0 : line_num+1; line_addr <= fb_base + target*32 (mod 2^ADDR_WIDTH); issue_cnt=ret_cnt=0; -> ISSUE.
- ISSUE: mem_read_req=1, mem_read_addr = line_addr + issue_cnt; issue_cnt increments on req & ready. Address and req held stable while ready=0. After the accept with issue_cnt==31 -> DRAIN (req drops the following cycle). Request throughput: 1 per cycle.
- Returns (ISSUE or DRAIN): buf_write_enable = mem_read_data_valid (combinational, same cycle); buf_write_addr = {fill_half, ret_cnt[4:0]}; buf_write_data = mem_read_data; ret_cnt increments per valid.
- DRAIN: mem_read_req=0; on valid with ret_cnt==31 -> IDLE next cycle.
- A return that arrives in IDLE is ignored: no write.
- Returns may coincide with requests; returns may arrive in the same cycle as the request is accepted only if memory permits. No ordering assumption beyond in-order returns.
- line_start while busy: underrun pulses next cycle; the line_start is dropped (no flip, no new fetch); the current fetch completes unchanged.
- line_start in the cycle the state returns to IDLE (last write cycle) counts as busy -> underrun.
- Reset mid-fetch: all state cleared immediately; the memory side must be reset together (in-flight returns are not tracked).
- Latency: line_start at cycle T -> scan_half flipped and first mem_read_req at T+1.

Decomposition:
- Shared display package: DISPLAY_WORDS_PER_LINE=32, DISPLAY_BUF_ADDR_WIDTH=6, state enum fetch_state_t {IDLE, ISSUE, DRAIN}.
- No sub-module; a single FSM with two 5-bit counters.

Test Plan:
- Reset, then line_start line_num=0, fb_base=0x1000, ready=1, 2-cycle return latency -> scan_half 0->1 at T+1; addrs 0x1020..0x103F; writes to buffer addrs 0..31 with the returned data; busy low after the 32nd write.
- Next line_start line_num=1 -> scan_half=0, addrs 0x1040..0x105F, writes to addrs 32..63.
- line_num=767 (LINE_COUNT-1), fb_base=0 -> addrs 0x0000..0x001F (wrap to line 0).
- Random ready stalls (~50%) -> addr/req stable while stalled; exactly 32 accepts, no duplicated or skipped address.
- line_start during ISSUE -> underrun 1-cycle pulse; scan_half unchanged; 32 writes still complete to the original half.
- Assert reset after 10 accepts -> all outputs return to reset values immediately; the next line_start starts a clean fetch at word 0.
